stream_packer: RTL and testbench

- Narrow-to-wide stream width converter; packs RATIO consecutive narrow beats into one wide word.
- Sits directly upstream of a wide sync_fifo instance and drives its wdata/wvalid/wready write port.
- A last-flagged input beat closes a partial word early; a per-lane keep mask marks the valid lanes.
- Registered output; no combinational path from wdata to rdata; sustains one input beat per cycle.

---
 rtl/stream_packer.sv | 114 +++++++++++
 tb/tb_stream_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO narrow beats (or fewer, closed by wlast)
// into one registered wide word with a per-lane keep mask.
module stream_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(RATIO)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        wlast,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [DATA_WIDTH*RATIO-1:0] rdata,
  output logic [RATIO-1:0]            rkeep,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready
);

  if (RATIO < 2) begin : g_bad_ratio
    $error("stream_packer: RATIO must be >= 2");
  end

  localparam int unsigned WordWidth = DATA_WIDTH * RATIO;
  localparam logic [CNT_WIDTH-1:0] LastLane = CNT_WIDTH'(RATIO - 1);

  logic [RATIO-2:0][DATA_WIDTH-1:0] lane_q, lane_d;
  logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
  logic [WordWidth-1:0]             rdata_q, rdata_d;
  logic [RATIO-1:0]                 rkeep_q, rkeep_d;
  logic                             rlast_q, rlast_d;
  logic                             rvalid_q, rvalid_d;

  logic                             completing;
  logic                             accept;
  logic [WordWidth-1:0]             word;
  logic [RATIO-1:0]                 keep;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rkeep_q  <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else if (flush) begin
      cnt_q    <= '0;
      rdata_q  <= '0;
      rkeep_q  <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rkeep_q  <= rkeep_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next-state logic
  always_comb begin
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rkeep_d  = rkeep_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q & ~rready;
    word     = '0;
    keep     = '0;

    // Lanes above cnt stay zero so stale accumulator contents never leak out.
    for (int i = 0; i < RATIO - 1; i++) begin
      if (CNT_WIDTH'(i) < cnt_q) word[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
    end
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_WIDTH'(i) == cnt_q) word[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
      if (CNT_WIDTH'(i) <= cnt_q) keep[i] = 1'b1;
    end

    if (accept) begin
      if (completing) begin
        rdata_d  = word;
        rkeep_d  = keep;
        rlast_d  = wlast;
        rvalid_d = 1'b1;
        cnt_d    = '0;
      end else begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (CNT_WIDTH'(i) == cnt_q) lane_d[i] = wdata;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output logic: only a completing beat needs the output register free.
  always_comb begin
    completing = (cnt_q == LastLane) | wlast;
    wready     = ~rvalid_q | rready | ~completing;
    accept     = wvalid & wready & ~flush;
  end

  assign rdata  = rdata_q;
  assign rkeep  = rkeep_q;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: vector table, corner-case sequences and a
// randomized run against a queue-based packing model.
module tb_stream_packer;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [7:0]  wdata;
  logic        wlast, wvalid, wready;
  logic [31:0] rdata;
  logic [3:0]  rkeep;
  logic        rlast, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  stream_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .wdata  (wdata),
    .wlast  (wlast),
    .wvalid (wvalid),
    .wready (wready),
    .rdata  (rdata),
    .rkeep  (rkeep),
    .rlast  (rlast),
    .rvalid (rvalid),
    .rready (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][7:0] d;
    logic            last;
    logic [31:0]     exp_data;
    logic [3:0]      exp_keep;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a beat (called at a negedge) and returns at the negedge after its acceptance.
  task automatic push(input logic [7:0] d, input logic l, output int waited);
    waited = 0;
    wdata  = d;
    wlast  = l;
    wvalid = 1'b1;
    #1;
    while (!wready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: wready stayed 0 for beat 0x%0h", d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t  vecs[5];
  int    w;
  logic [7:0]  in_data[$];
  logic        in_last[$];
  word_t       exp_q[$];

  initial begin
    reset = 1'b1; flush = 1'b0; wdata = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b1;
    vecs[0] = '{4, 32'h44332211, 1'b1, 32'h44332211, 4'b1111};
    vecs[1] = '{2, 32'h0000A2A1, 1'b1, 32'h0000A2A1, 4'b0011};
    vecs[2] = '{1, 32'h000000B1, 1'b1, 32'h000000B1, 4'b0001};
    vecs[3] = '{4, 32'hDDCCBBAA, 1'b0, 32'hDDCCBBAA, 4'b1111};
    vecs[4] = '{3, 32'h00C3C2C1, 1'b1, 32'h00C3C2C1, 4'b0111};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check("reset_rkeep", rkeep, 0);
    check("reset_rlast", rlast, 0);
    check("reset_wready", wready, 1);
    @(negedge clk);

    // Vector table, rready held high.
    foreach (vecs[v]) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        push(vecs[v].d[b], (b == vecs[v].n - 1) ? vecs[v].last : 1'b0, w);
        if (b < vecs[v].n - 1) check($sformatf("vec%0d_early_rvalid", v), rvalid, 0);
      end
      wvalid = 1'b0;
      check($sformatf("vec%0d_rvalid", v), rvalid, 1);
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_data);
      check($sformatf("vec%0d_rkeep", v), rkeep, vecs[v].exp_keep);
      check($sformatf("vec%0d_rlast", v), rlast, vecs[v].last);
      @(negedge clk);
      check($sformatf("vec%0d_drain", v), rvalid, 0);
    end

    // Stall: held word, three more non-completing beats still accepted.
    rready = 1'b0;
    push(8'h11, 1'b0, w); push(8'h22, 1'b0, w); push(8'h33, 1'b0, w); push(8'h44, 1'b0, w);
    check("stall_word", rdata, 32'h44332211);
    push(8'h55, 1'b0, w); check("stall_acc1", w, 0);
    push(8'h66, 1'b0, w); check("stall_acc2", w, 0);
    push(8'h77, 1'b0, w); check("stall_acc3", w, 0);
    wdata = 8'h88; wlast = 1'b0; wvalid = 1'b1;
    #1;
    check("stall_wready0", wready, 0);
    check("stall_hold_rdata", rdata, 32'h44332211);
    check("stall_hold_rvalid", rvalid, 1);
    @(negedge clk);
    #1;
    check("stall_wready0b", wready, 0);
    check("stall_hold_rdata_b", rdata, 32'h44332211);
    rready = 1'b1;
    #1;
    check("stall_wready1", wready, 1);
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    check("stall_next_rvalid", rvalid, 1);
    check("stall_next_rdata", rdata, 32'h88776655);
    check("stall_next_rkeep", rkeep, 4'b1111);
    check("stall_next_rlast", rlast, 0);
    @(negedge clk);
    check("stall_drained", rvalid, 0);

    // Full-rate streaming.
    for (int i = 0; i < 32; i++) begin
      wdata = 8'(i); wlast = 1'b0; wvalid = 1'b1;
      #1;
      check($sformatf("stream_wready%0d", i), wready, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stream_rvalid%0d", i), rvalid, (i % 4 == 3));
      if (i % 4 == 3)
        check($sformatf("stream_rdata%0d", i), rdata,
              {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
    end
    wvalid = 1'b0;
    @(negedge clk);

    // Flush then reset mid-word discard the partial word.
    for (int pass = 0; pass < 2; pass++) begin
      push(8'h55, 1'b0, w);
      push(8'h66, 1'b0, w);
      wvalid = 1'b0;
      if (pass == 0) flush = 1'b1; else reset = 1'b1;
      @(negedge clk);
      flush = 1'b0; reset = 1'b0;
      check($sformatf("clr%0d_rvalid", pass), rvalid, 0);
      check($sformatf("clr%0d_rkeep", pass), rkeep, 0);
      push(8'h77, 1'b1, w);
      wvalid = 1'b0;
      check($sformatf("clr%0d_rdata", pass), rdata, 32'h00000077);
      check($sformatf("clr%0d_rkeep2", pass), rkeep, 4'b0001);
      check($sformatf("clr%0d_rlast", pass), rlast, 1);
      @(negedge clk);
    end

    // Randomized run against a queue model of the packing rules.
    begin
      int          idx = 0, cycles = 0, n_wlast = 0, n_rlast = 0, nacc = 0;
      logic [31:0] acc = '0;
      logic        stalled = 1'b0;
      word_t       prev, cur, e;
      for (int p = 0; p < 40; p++) begin
        int len = $urandom_range(1, 11);
        for (int b = 0; b < len; b++) begin
          in_data.push_back(8'($urandom));
          in_last.push_back(b == len - 1);
        end
      end
      while ((idx < in_data.size() || exp_q.size() > 0) && cycles < 5000) begin
        cycles++;
        wvalid = (idx < in_data.size()) && ($urandom_range(0, 3) != 0);
        wdata  = wvalid ? in_data[idx] : 8'($urandom);
        wlast  = wvalid ? in_last[idx] : 1'($urandom);
        rready = ($urandom_range(0, 2) != 0);
        #1;
        cur = '{rdata, rkeep, rlast};
        if (stalled) check("rand_hold", {rvalid, cur.d, cur.k, cur.l}, {1'b1, prev.d, prev.k, prev.l});
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            check("rand_unexpected_word", rvalid, 0);
          end else begin
            e = exp_q.pop_front();
            check("rand_word", {cur.d, cur.k, cur.l}, {e.d, e.k, e.l});
            if (rlast) n_rlast++;
          end
        end
        stalled = rvalid && !rready;
        prev    = cur;
        if (wvalid && wready) begin
          acc[nacc*8 +: 8] = wdata;
          nacc++;
          if (wlast) n_wlast++;
          if (nacc == 4 || wlast) begin
            exp_q.push_back('{acc, 4'((1 << nacc) - 1), wlast});
            acc  = '0;
            nacc = 0;
          end
          idx++;
        end
        @(posedge clk);
        @(negedge clk);
      end
      wvalid = 1'b0;
      check("rand_all_sent", idx, in_data.size());
      check("rand_all_drained", exp_q.size(), 0);
      check("rand_rlast_count", n_rlast, n_wlast);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
